// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between pipeline writeback and a long-latency unit,
// with a pending-write scoreboard. Define RF_WB_STARVE_GUARD_EN to enable forced grants.
module rf_wb_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_wb_valid,
    input  logic [4:0]        pipe_wb_rd,
    input  logic [DATA_W-1:0] pipe_wb_data,
    input  logic              ll_valid,
    input  logic [4:0]        ll_rd,
    input  logic [DATA_W-1:0] ll_data,
    output logic              ll_ready,
    output logic              stall_pipe,
    input  logic              iss_valid,
    input  logic              iss_ll,
    input  logic [4:0]        iss_rd,
    input  logic [4:0]        src_a,
    input  logic [4:0]        src_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              busy_d,
    output logic              rf_load,
    output logic [4:0]        rf_dest,
    output logic [DATA_W-1:0] rf_data
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned NREG  = 32;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FORCE} state_t;

    state_t          state;
    logic            pipe_eff_c;
    logic            pipe_grant_c;
    logic            force_c;
    logic            blocked_c;
    logic            go_force_c;
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt_c;

    // Grant: effective pipeline write wins unless a forced grant is in progress
    assign pipe_eff_c   = pipe_wb_valid && (pipe_wb_rd != 5'd0);
    assign ll_ready     = rst_n && ll_valid && (force_c || !pipe_eff_c);
    assign pipe_grant_c = pipe_eff_c && !force_c;
    assign blocked_c    = ll_valid && !ll_ready;

`ifdef RF_WB_STARVE_GUARD_EN
    logic [CNT_W-1:0] wait_cnt;
    logic             thresh_c;

    assign force_c    = (state == ST_FORCE);
    assign thresh_c   = (wait_cnt >= CNT_W'(STARVE_MAX - 1));
    assign go_force_c = blocked_c && thresh_c;

    // Consecutive blocked cycles; saturates rather than wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt   <= '0;
            stall_pipe <= 1'b0;
        end else begin
            if (!blocked_c)
                wait_cnt <= '0;
            else if (wait_cnt != '1)
                wait_cnt <= wait_cnt + CNT_W'(1);
            stall_pipe <= go_force_c;
        end
    end
`else
    assign force_c    = 1'b0;
    assign go_force_c = 1'b0;
    assign stall_pipe = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_WAIT: begin
                    if (go_force_c)
                        state <= ST_FORCE;
                    else if (blocked_c)
                        state <= ST_WAIT;
                    else
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Registered regfile write; x0 long-latency results are accepted but not written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_load <= 1'b0;
            rf_dest <= '0;
            rf_data <= '0;
        end else if (pipe_grant_c) begin
            rf_load <= 1'b1;
            rf_dest <= pipe_wb_rd;
            rf_data <= pipe_wb_data;
        end else if (ll_ready && (ll_rd != 5'd0)) begin
            rf_load <= 1'b1;
            rf_dest <= ll_rd;
            rf_data <= ll_data;
        end else begin
            rf_load <= 1'b0;
        end
    end

    // Scoreboard update: a new issue to the same register overrides the retiring clear
    always_comb begin
        pending_nxt_c = pending;
        if (ll_ready)
            pending_nxt_c[ll_rd] = 1'b0;
        if (iss_valid && iss_ll && (iss_rd != 5'd0))
            pending_nxt_c[iss_rd] = 1'b1;
        pending_nxt_c[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending <= '0;
        else
            pending <= pending_nxt_c;
    end

    assign busy_a = pending[src_a];
    assign busy_b = pending[src_b];
    assign busy_d = pending[iss_rd];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed vectors, corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_rf_wb_arbiter;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STARVE_MAX = 4;
`ifdef RF_WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              pipe_wb_valid;
    logic [4:0]        pipe_wb_rd;
    logic [DATA_W-1:0] pipe_wb_data;
    logic              ll_valid;
    logic [4:0]        ll_rd;
    logic [DATA_W-1:0] ll_data;
    logic              ll_ready;
    logic              stall_pipe;
    logic              iss_valid;
    logic              iss_ll;
    logic [4:0]        iss_rd;
    logic [4:0]        src_a;
    logic [4:0]        src_b;
    logic              busy_a;
    logic              busy_b;
    logic              busy_d;
    logic              rf_load;
    logic [4:0]        rf_dest;
    logic [DATA_W-1:0] rf_data;

    rf_wb_arbiter #(.DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_wb_valid(pipe_wb_valid), .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
        .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data), .ll_ready(ll_ready),
        .stall_pipe(stall_pipe),
        .iss_valid(iss_valid), .iss_ll(iss_ll), .iss_rd(iss_rd),
        .src_a(src_a), .src_b(src_b),
        .busy_a(busy_a), .busy_b(busy_b), .busy_d(busy_d),
        .rf_load(rf_load), .rf_dest(rf_dest), .rf_data(rf_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [31:0]       m_pending;
    int                m_run;
    bit                m_force;
    bit                m_load;
    logic [4:0]        m_dest;
    logic [DATA_W-1:0] m_data;
    bit                m_last_ready;

    typedef struct {
        logic              pv;
        logic [4:0]        prd;
        logic [DATA_W-1:0] pdata;
        logic              lv;
        logic [4:0]        lrd;
        logic [DATA_W-1:0] ldata;
        logic              e_ready;
        logic              e_load;
        logic [4:0]        e_dest;
        logic [DATA_W-1:0] e_data;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_pending    = '0;
        m_run        = 0;
        m_force      = 1'b0;
        m_load       = 1'b0;
        m_dest       = '0;
        m_data       = '0;
        m_last_ready = 1'b0;
    endtask

    task automatic idle_inputs();
        pipe_wb_valid = 1'b0; pipe_wb_rd = '0; pipe_wb_data = '0;
        ll_valid = 1'b0; ll_rd = '0; ll_data = '0;
        iss_valid = 1'b0; iss_ll = 1'b0; iss_rd = '0;
        src_a = '0; src_b = '0;
    endtask

    // One clock: compare DUT to the model, then advance the model at the edge
    task automatic tick();
        bit                eff, e_ready, blocked, n_load, n_force;
        logic [4:0]        n_dest;
        logic [DATA_W-1:0] n_data;
        logic [31:0]       n_pend;
        int                n_run;
        #1;
        eff     = pipe_wb_valid && (pipe_wb_rd != 5'd0);
        e_ready = ll_valid && (m_force || !eff);
        chk("ll_ready",   32'(ll_ready),   32'(e_ready));
        chk("stall_pipe", 32'(stall_pipe), 32'(m_force));
        chk("rf_load",    32'(rf_load),    32'(m_load));
        chk("rf_dest",    32'(rf_dest),    32'(m_dest));
        chk("rf_data",    32'(rf_data),    32'(m_data));
        chk("busy_a",     32'(busy_a),     32'(m_pending[src_a]));
        chk("busy_b",     32'(busy_b),     32'(m_pending[src_b]));
        chk("busy_d",     32'(busy_d),     32'(m_pending[iss_rd]));
        n_dest = m_dest;
        n_data = m_data;
        n_load = 1'b0;
        if (eff && !m_force) begin
            n_load = 1'b1; n_dest = pipe_wb_rd; n_data = pipe_wb_data;
        end else if (e_ready && ll_rd != 5'd0) begin
            n_load = 1'b1; n_dest = ll_rd; n_data = ll_data;
        end
        n_pend = m_pending;
        if (e_ready) n_pend[ll_rd] = 1'b0;
        if (iss_valid && iss_ll && iss_rd != 5'd0) n_pend[iss_rd] = 1'b1;
        n_pend[0] = 1'b0;
        blocked = ll_valid && !e_ready;
        n_run   = blocked ? m_run + 1 : 0;
        n_force = GUARD && blocked && (n_run >= int'(STARVE_MAX));
        @(posedge clk);
        m_load = n_load; m_dest = n_dest; m_data = n_data;
        m_pending = n_pend; m_run = n_run; m_force = n_force;
        m_last_ready = e_ready;
        @(negedge clk);
    endtask

    initial begin
        bit accepted;
        bit exp_force;

        vt[0] = '{1'b1, 5'd3,  32'h0000_0011, 1'b0, 5'd0, 32'h0,          1'b0, 1'b1, 5'd3,  32'h0000_0011};
        vt[1] = '{1'b1, 5'd0,  32'h0000_0022, 1'b1, 5'd4, 32'h0000_0044,  1'b1, 1'b1, 5'd4,  32'h0000_0044};
        vt[2] = '{1'b1, 5'd0,  32'h0000_0033, 1'b0, 5'd0, 32'h0,          1'b0, 1'b0, 5'd4,  32'h0000_0044};
        vt[3] = '{1'b1, 5'd5,  32'h0000_0055, 1'b1, 5'd6, 32'h0000_0066,  1'b0, 1'b1, 5'd5,  32'h0000_0055};
        vt[4] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0, 32'h0000_0077,  1'b1, 1'b0, 5'd5,  32'h0000_0055};
        vt[5] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'h0,          1'b0, 1'b0, 5'd5,  32'h0000_0055};
        vt[6] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0,          1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF};

        // Reset state, with a long-latency request already present
        idle_inputs();
        ll_valid = 1'b1;
        rst_n = 1'b0;
        model_reset();
        #3;
        chk("rst_ll_ready", 32'(ll_ready), 32'd0);
        chk("rst_rf_load",  32'(rf_load),  32'd0);
        chk("rst_rf_dest",  32'(rf_dest),  32'd0);
        chk("rst_rf_data",  32'(rf_data),  32'd0);
        chk("rst_stall",    32'(stall_pipe), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();

        // Uncontended long-latency write
        ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'hDEAD_BEEF;
        #1 chk("ll_alone_ready", 32'(ll_ready), 32'd1);
        tick();
        idle_inputs();
        #1;
        chk("ll_alone_load", 32'(rf_load), 32'd1);
        chk("ll_alone_dest", 32'(rf_dest), 32'd7);
        chk("ll_alone_data", 32'(rf_data), 32'hDEAD_BEEF);
        tick();

        // Directed vector table: each record followed by an idle cycle
        for (int i = 0; i < 7; i++) begin
            pipe_wb_valid = vt[i].pv; pipe_wb_rd = vt[i].prd; pipe_wb_data = vt[i].pdata;
            ll_valid = vt[i].lv; ll_rd = vt[i].lrd; ll_data = vt[i].ldata;
            #1 chk($sformatf("tbl%0d_ready", i), 32'(ll_ready), 32'(vt[i].e_ready));
            tick();
            idle_inputs();
            #1;
            chk($sformatf("tbl%0d_load", i), 32'(rf_load), 32'(vt[i].e_load));
            chk($sformatf("tbl%0d_dest", i), 32'(rf_dest), 32'(vt[i].e_dest));
            chk($sformatf("tbl%0d_data", i), 32'(rf_data), vt[i].e_data);
            tick();
        end

        // Starvation under a continuous pipeline stream to x3
        accepted = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd3; pipe_wb_data = 32'(c);
            ll_valid = !accepted; ll_rd = 5'd9; ll_data = 32'h0000_0900;
            exp_force = GUARD && (c == 5);
            #1;
            chk($sformatf("starve_c%0d_stall", c), 32'(stall_pipe), 32'(exp_force));
            chk($sformatf("starve_c%0d_ready", c), 32'(ll_ready), 32'(exp_force));
            if (GUARD && c == 6) begin
                chk("starve_dest9", 32'(rf_dest), 32'd9);
                chk("starve_data",  32'(rf_data), 32'h0000_0900);
            end
            tick();
            if (m_last_ready) accepted = 1'b1;
        end
        idle_inputs();
        tick();

        // Scoreboard: busy until the cycle after the rd=12 handshake
        iss_valid = 1'b1; iss_ll = 1'b1; iss_rd = 5'd12; src_a = 5'd12;
        #1 chk("sb12_before", 32'(busy_a), 32'd0);
        tick();
        iss_valid = 1'b0;
        #1 chk("sb12_set", 32'(busy_a), 32'd1);
        tick();
        ll_valid = 1'b1; ll_rd = 5'd12; ll_data = 32'h1212;
        #1 chk("sb12_hs_cycle", 32'(busy_a), 32'd1);
        tick();
        ll_valid = 1'b0;
        #1 chk("sb12_cleared", 32'(busy_a), 32'd0);
        tick();

        // Same-cycle clear and re-issue of rd=5: set wins
        idle_inputs();
        iss_valid = 1'b1; iss_ll = 1'b1; iss_rd = 5'd5;
        tick();
        ll_valid = 1'b1; ll_rd = 5'd5; ll_data = 32'h5;
        #1 chk("sb5_hs", 32'(ll_ready), 32'd1);
        tick();
        idle_inputs();
        src_b = 5'd5;
        #1 chk("sb5_kept", 32'(busy_b), 32'd1);
        tick();
        ll_valid = 1'b1; ll_rd = 5'd5;
        tick();
        idle_inputs();
        tick();

        // Asynchronous reset mid-wait with pending bits set
        iss_valid = 1'b1; iss_ll = 1'b1; iss_rd = 5'd10;
        tick();
        iss_valid = 1'b0; src_a = 5'd10;
        pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd3; pipe_wb_data = 32'hAB;
        ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h99;
        tick();
        tick();
        #2;
        chk("midrst_busy_pre", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ll_ready", 32'(ll_ready), 32'd0);
        chk("midrst_stall",    32'(stall_pipe), 32'd0);
        chk("midrst_rf_load",  32'(rf_load), 32'd0);
        chk("midrst_rf_dest",  32'(rf_dest), 32'd0);
        chk("midrst_rf_data",  32'(rf_data), 32'd0);
        chk("midrst_busy_a",   32'(busy_a), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        tick();

        // Randomized traffic; long-latency request held until accepted
        for (int n = 0; n < 600; n++) begin
            if (!(ll_valid && !m_last_ready)) begin
                ll_valid = ($urandom_range(0, 99) < 45);
                ll_rd    = 5'($urandom_range(0, 31));
                ll_data  = $urandom;
            end
            pipe_wb_valid = ($urandom_range(0, 99) < 70);
            pipe_wb_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            pipe_wb_data  = $urandom;
            iss_valid     = ($urandom_range(0, 1) == 1);
            iss_ll        = ($urandom_range(0, 2) == 0);
            iss_rd        = 5'($urandom_range(0, 31));
            src_a         = 5'($urandom_range(0, 31));
            src_b         = 5'($urandom_range(0, 31));
            tick();
            if (m_last_ready) ll_valid = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
